// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master read path: byte FSM states,
// ACK/NACK line levels and the default byte width.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      ACK,
      DONE,
      WAIT_REL
   } state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam int DEFAULT_BIT_COUNT = 8;

endpackage

// File: rtl/i2c_master_read_byte.sv
// Byte-level read sequencer: collects BIT_COUNT bits MSB-first from the read-bit
// stage, then returns ACK/NACK through the write-bit stage.
// Optional per-stage watchdog: define I2C_READ_BYTE_WATCHDOG_EN.
//
// Handshake: bit_go/wbit_go are level enables held high while a sub-stage is
// wanted; bit_finish/wbit_finish are one-cycle completion pulses that are only
// honoured in READ/ACK respectively; finish (with error on failure) is a
// one-cycle pulse to the controller, after which go must drop before a new byte.
module i2c_master_read_byte
   import i2c_pkg::*;
#(
   parameter int BIT_COUNT  = DEFAULT_BIT_COUNT,
   parameter int WDT_CYCLES = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 go,
   input  logic                 ack_en,
   output logic [BIT_COUNT-1:0] data_out,
   output logic                 finish,
   output logic                 error,
   output logic                 bit_go,
   input  logic                 bit_data,
   input  logic                 bit_finish,
   input  logic                 bit_error,
   output logic                 wbit_go,
   output logic                 wbit_data,
   input  logic                 wbit_finish
);

   localparam int CW = $clog2(BIT_COUNT + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(BIT_COUNT - 1);

   state_t               state_q, state_d;
   logic [BIT_COUNT-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ack_q, ack_d;
   logic [BIT_COUNT-1:0] data_d;
   logic                 finish_d, error_d, bit_go_d, wbit_go_d, wbit_data_d;
   logic                 wdt_clr;
   logic                 wdt_expired;

`ifdef I2C_READ_BYTE_WATCHDOG_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);
   logic [WW-1:0] wdt_q;

   // Expires on the edge where the count would reach WDT_CYCLES.
   assign wdt_expired = (wdt_q == WW'(WDT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wdt_q <= '0;
      end else if (wdt_clr) begin
         wdt_q <= '0;
      end else if ((state_q == READ) || (state_q == ACK)) begin
         wdt_q <= wdt_q + WW'(1);
      end
   end
`else
   logic unused_wdt;
   assign unused_wdt  = (WDT_CYCLES > 0) | wdt_clr;
   assign wdt_expired = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         data_out  <= '0;
         finish    <= 1'b0;
         error     <= 1'b0;
         bit_go    <= 1'b0;
         wbit_go   <= 1'b0;
         wbit_data <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         data_out  <= data_d;
         finish    <= finish_d;
         error     <= error_d;
         bit_go    <= bit_go_d;
         wbit_go   <= wbit_go_d;
         wbit_data <= wbit_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      ack_d       = ack_q;
      data_d      = data_out;
      finish_d    = 1'b0;
      error_d     = 1'b0;
      bit_go_d    = bit_go;
      wbit_go_d   = wbit_go;
      wbit_data_d = wbit_data;
      wdt_clr     = 1'b0;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d  = READ;
               bit_go_d = 1'b1;
               ack_d    = ack_en;
               shift_d  = '0;
               cnt_d    = '0;
               wdt_clr  = 1'b1;
            end
         end
         READ: begin
            // Abort takes priority over a coincident bit_finish.
            if (!go) begin
               state_d   = IDLE;
               bit_go_d  = 1'b0;
               wbit_go_d = 1'b0;
               shift_d   = '0;
               cnt_d     = '0;
            end else if (bit_finish) begin
               wdt_clr = 1'b1;
               if (bit_error) begin
                  state_d  = DONE;
                  bit_go_d = 1'b0;
                  finish_d = 1'b1;
                  error_d  = 1'b1;
               end else begin
                  shift_d = {shift_q[BIT_COUNT-2:0], bit_data};
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == LAST_BIT) begin
                     state_d     = ACK;
                     bit_go_d    = 1'b0;
                     wbit_go_d   = 1'b1;
                     wbit_data_d = ack_q ? I2C_ACK : I2C_NACK;
                  end
               end
            end else if (wdt_expired) begin
               state_d  = DONE;
               bit_go_d = 1'b0;
               finish_d = 1'b1;
               error_d  = 1'b1;
            end
         end
         ACK: begin
            if (!go) begin
               state_d   = IDLE;
               bit_go_d  = 1'b0;
               wbit_go_d = 1'b0;
               shift_d   = '0;
               cnt_d     = '0;
            end else if (wbit_finish) begin
               state_d   = DONE;
               wbit_go_d = 1'b0;
               data_d    = shift_q;
               finish_d  = 1'b1;
            end else if (wdt_expired) begin
               state_d   = DONE;
               wbit_go_d = 1'b0;
               finish_d  = 1'b1;
               error_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!go) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Directed bench for i2c_master_read_byte: models both bit stages and checks
// every finish pulse against an expected-response queue.
module tb_i2c_master_read_byte;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       go = 1'b0;
   logic       ack_en = 1'b0;
   logic [7:0] data_out;
   logic       finish;
   logic       error;
   logic       bit_go;
   logic       bit_data = 1'b0;
   logic       bit_finish = 1'b0;
   logic       bit_error = 1'b0;
   logic       wbit_go;
   logic       wbit_data;
   logic       wbit_finish = 1'b0;

   int         checks = 0;
   int         errors = 0;
   int         finish_seen = 0;
   int         finish_exp = 0;
   logic [8:0] exp_q[$];
   logic [7:0] last_good = 8'h00;

   i2c_master_read_byte #(.BIT_COUNT(8), .WDT_CYCLES(32)) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .ack_en(ack_en),
      .data_out(data_out), .finish(finish), .error(error),
      .bit_go(bit_go), .bit_data(bit_data), .bit_finish(bit_finish),
      .bit_error(bit_error), .wbit_go(wbit_go), .wbit_data(wbit_data),
      .wbit_finish(wbit_finish)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_finish(input logic err, input logic [7:0] data);
      exp_q.push_back({err, data});
      finish_exp++;
   endtask

   // Response monitor: every finish pulse must match the oldest expectation.
   always @(negedge clock) begin : monitor
      logic [8:0] e;
      if (reset_n && finish === 1'b1) begin
         finish_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_finish actual=%0h required=none", {error, data_out});
         end else begin
            e = exp_q.pop_front();
            check("finish_resp", {23'd0, error, data_out}, {23'd0, e});
         end
      end
   end

   // Drives one byte through the read-bit model; err_at / abort_after of -1 disable them.
   task automatic do_byte(input logic [7:0] bits, input logic ack, input int err_at,
                          input int abort_after);
      logic seen;
      @(negedge clock);
      go = 1'b1;
      ack_en = ack;
      @(negedge clock);
      check("bit_go_start", {31'd0, bit_go}, 32'd1);
      ack_en = ~ack;
      for (int i = 0; i < 8; i++) begin
         repeat (2) @(negedge clock);
         bit_data = bits[7-i];
         bit_finish = 1'b1;
         bit_error = (i == err_at);
         if (i == err_at) expect_finish(1'b1, last_good);
         @(negedge clock);
         bit_finish = 1'b0;
         bit_error = 1'b0;
         bit_data = 1'b0;
         if (i == err_at) begin
            check("err_bit_go", {31'd0, bit_go}, 32'd0);
            seen = wbit_go;
            repeat (5) begin
               @(negedge clock);
               seen = seen | wbit_go;
            end
            check("err_no_wbit_go", {31'd0, seen}, 32'd0);
            go = 1'b0;
            @(negedge clock);
            return;
         end
         if (i + 1 == abort_after) begin
            go = 1'b0;
            @(negedge clock);
            check("abort_bit_go", {31'd0, bit_go}, 32'd0);
            check("abort_wbit_go", {31'd0, wbit_go}, 32'd0);
            repeat (3) @(negedge clock);
            return;
         end
      end
      check("ack_bit_go_low", {31'd0, bit_go}, 32'd0);
      check("ack_wbit_go", {31'd0, wbit_go}, 32'd1);
      check("ack_wbit_data", {31'd0, wbit_data}, ack ? 32'd0 : 32'd1);
      @(negedge clock);
      expect_finish(1'b0, bits);
      wbit_finish = 1'b1;
      @(negedge clock);
      wbit_finish = 1'b0;
      last_good = bits;
      check("ack_wbit_go_drop", {31'd0, wbit_go}, 32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         seen = seen | bit_go | wbit_go;
      end
      check("wait_rel_no_retrigger", {31'd0, seen}, 32'd0);
      go = 1'b0;
      @(negedge clock);
   endtask

   initial begin : main
      int k;
      repeat (2) @(negedge clock);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_finish", {31'd0, finish}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_bit_go", {31'd0, bit_go}, 32'd0);
      check("rst_wbit_go", {31'd0, wbit_go}, 32'd0);
      check("rst_wbit_data", {31'd0, wbit_data}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      do_byte(8'hA5, 1'b1, -1, -1);
      do_byte(8'hFF, 1'b0, -1, -1);
      do_byte(8'h12, 1'b1, 3, -1);
      check("err_data_hold", {24'd0, data_out}, 32'h0000_00FF);
      do_byte(8'h81, 1'b1, -1, 3);
      check("abort_data_hold", {24'd0, data_out}, 32'h0000_00FF);
      do_byte(8'h3C, 1'b1, -1, -1);
      check("fresh_byte", {24'd0, data_out}, 32'h0000_003C);

      // Silent read-bit stage.
      @(negedge clock);
      go = 1'b1;
      @(negedge clock);
      check("silent_bit_go", {31'd0, bit_go}, 32'd1);
`ifdef I2C_READ_BYTE_WATCHDOG_EN
      expect_finish(1'b1, last_good);
      k = 0;
      while (finish !== 1'b1 && k < 100) begin
         @(negedge clock);
         k++;
      end
      check("wdt_latency", k, 32'd32);
      check("wdt_bit_go_drop", {31'd0, bit_go}, 32'd0);
`else
      k = finish_seen;
      repeat (60) @(negedge clock);
      check("no_wdt_no_finish", finish_seen, k);
      check("no_wdt_bit_go_held", {31'd0, bit_go}, 32'd1);
`endif
      go = 1'b0;
      repeat (2) @(negedge clock);

      // Asynchronous reset in the middle of a byte.
      go = 1'b1;
      repeat (2) @(negedge clock);
      check("mid_bit_go", {31'd0, bit_go}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_bit_go", {31'd0, bit_go}, 32'd0);
      check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
      go = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      check("queue_empty", exp_q.size(), 32'd0);
      check("finish_count", finish_seen, finish_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
